mem_ctrl: RTL

- Multi-cycle memory controller and arbiter for the 5-stage pipeline.
- Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises 1/2/4-byte transfers and returns a one-cycle done pulse. The pipeline uses that pulse to release its stage-register stalls (e.g. id_ex_stall).
- MEM has priority. An in-flight fetch is aborted on a taken jump.

---
 rtl/mem_ctrl_if.sv | 33 +++
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the pipeline's fetch/load-store requesters, mem_ctrl and the byte-wide RAM.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_data;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide RAM port between instruction fetch and load/store, serialising
// 1/2/4-byte transfers and returning a one-cycle done pulse to the requester.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       jump_or_not,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic              is_if_q, is_if_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    // NOTE: every *_d takes its held value first, so no path through this block infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    is_if_d     = is_if_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        // Waiting out a high done pulse keeps a still-asserted request from being re-granted.
        if (!if_done_q && !mem_done_q) begin
          if (bus.mem_req) begin
            is_if_d = 1'b0;
            addr_d  = bus.mem_addr;
            wdata_d = bus.mem_wdata;
            n_d     = size_to_n(bus.mem_size);
            state_d = bus.mem_we ? WRITE : READ;
          end else if (bus.if_req && !jump_or_not) begin
            is_if_d = 1'b1;
            addr_d  = bus.if_addr;
            n_d     = 3'd4;
            state_d = READ;
          end
          if (state_d == WRITE) begin
            ram_a_d    = addr_d;
            ram_dout_d = wdata_d[7:0];
            ram_wr_d   = 1'b1;
            cnt_d      = 3'd1;
          end else if (state_d == READ) begin
            ram_a_d = addr_d;
            buf_d   = '0;
            cnt_d   = 3'd0;
          end
        end
      end

      READ: begin
        if (jump_or_not && is_if_q) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          buf_d[{cnt_q[1:0], 3'b000} +: 8] = bus.ram_din;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 < n_q) begin
            ram_a_d = addr_q + ADDR_W'(cnt_q + 3'd1);
          end else begin
            state_d = IDLE;
            if (is_if_q) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = buf_d;
            end
          end
        end
      end

      WRITE: begin
        if (cnt_q < n_q) begin
          ram_a_d    = addr_q + ADDR_W'(cnt_q);
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end else begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      is_if_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      is_if_q     <= is_if_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;
  // A frozen pipeline must not keep writing the byte it is parked on.
  assign bus.ram_wr    = ram_wr_q & rdy;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;

endmodule
